// File: rtl/even_count_scanner.sv
// even_count_scanner: sweeps a 256x8 eight-port array in 8-entry beats and
// counts non-zero even entries, in total and per 64-entry quarter.
module even_count_scanner #(
  parameter int EXCLUDE_ZERO = 1,
  parameter int NUM_BEATS    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] AddressBus0,
  output logic [7:0] AddressBus1,
  output logic [7:0] AddressBus2,
  output logic [7:0] AddressBus3,
  output logic [7:0] AddressBus4,
  output logic [7:0] AddressBus5,
  output logic [7:0] AddressBus6,
  output logic [7:0] AddressBus7,
  input  logic [7:0] DataBus0,
  input  logic [7:0] DataBus1,
  input  logic [7:0] DataBus2,
  input  logic [7:0] DataBus3,
  input  logic [7:0] DataBus4,
  input  logic [7:0] DataBus5,
  input  logic [7:0] DataBus6,
  input  logic [7:0] DataBus7,
  output logic       busy,
  output logic       done,
  output logic [8:0] count,
  output logic [6:0] qcount0,
  output logic [6:0] qcount1,
  output logic [6:0] qcount2,
  output logic [6:0] qcount3
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [4:0] LAST = 5'(NUM_BEATS - 1);

  state_t     state_q, state_d;
  logic [4:0] beat_q, beat_d;
  logic [8:0] count_q, count_d;
  logic [6:0] qcnt_q [4];
  logic [6:0] qcnt_d [4];

  logic [7:0] data [8];
  logic [7:0] base;
  logic [7:0] hit;
  logic [3:0] pop;
  logic [1:0] quad;

  assign data[0] = DataBus0;
  assign data[1] = DataBus1;
  assign data[2] = DataBus2;
  assign data[3] = DataBus3;
  assign data[4] = DataBus4;
  assign data[5] = DataBus5;
  assign data[6] = DataBus6;
  assign data[7] = DataBus7;

  // beat is 0 outside SCAN, so idle ports present addresses 0..7
  assign base        = {beat_q, 3'b000};
  assign AddressBus0 = base + 8'd0;
  assign AddressBus1 = base + 8'd1;
  assign AddressBus2 = base + 8'd2;
  assign AddressBus3 = base + 8'd3;
  assign AddressBus4 = base + 8'd4;
  assign AddressBus5 = base + 8'd5;
  assign AddressBus6 = base + 8'd6;
  assign AddressBus7 = base + 8'd7;

  assign quad = beat_q[4:3];

  always_comb begin
    hit = '0;
    pop = '0;
    for (int k = 0; k < 8; k++) begin
      hit[k] = (data[k][0] == 1'b0) &&
               ((EXCLUDE_ZERO == 0) || (data[k] != 8'd0));
      pop    = pop + {3'b000, hit[k]};
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    count_d = count_q;
    qcnt_d  = qcnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SCAN;
          beat_d  = '0;
          count_d = '0;
          qcnt_d  = '{default: '0};
        end
      end
      SCAN: begin
        count_d      = count_q + {5'b00000, pop};
        qcnt_d[quad] = qcnt_q[quad] + {3'b000, pop};
        if (beat_q == LAST) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      count_q <= '0;
      qcnt_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      count_q <= count_d;
      qcnt_q  <= qcnt_d;
    end
  end

  assign busy    = (state_q == SCAN);
  assign done    = (state_q == DONE);
  assign count   = count_q;
  assign qcount0 = qcnt_q[0];
  assign qcount1 = qcnt_q[1];
  assign qcount2 = qcnt_q[2];
  assign qcount3 = qcnt_q[3];

endmodule

// File: tb/tb_even_count_scanner.sv
// Bench for even_count_scanner: array model, scoreboard of expected counts,
// two instances (zero excluded / zero counted) sharing one image.
module tb_even_count_scanner;

  typedef struct packed {
    logic [8:0]      c;
    logic [3:0][6:0] q;
  } res_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem [256];

  logic [7:0] addr_a [8];
  logic [7:0] data_a [8];
  logic [7:0] addr_z [8];
  logic [7:0] data_z [8];
  logic       busy_a, done_a, busy_z, done_z;
  logic [8:0] cnt_a, cnt_z;
  logic [6:0] qc_a [4];
  logic [6:0] qc_z [4];

  int   checks = 0;
  int   failures = 0;
  res_t sb_q [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 8; k++) begin : g_rd
    assign data_a[k] = mem[addr_a[k]];
    assign data_z[k] = mem[addr_z[k]];
  end

  even_count_scanner dut (
    .clk(clk), .reset(reset), .start(start),
    .AddressBus0(addr_a[0]), .AddressBus1(addr_a[1]),
    .AddressBus2(addr_a[2]), .AddressBus3(addr_a[3]),
    .AddressBus4(addr_a[4]), .AddressBus5(addr_a[5]),
    .AddressBus6(addr_a[6]), .AddressBus7(addr_a[7]),
    .DataBus0(data_a[0]), .DataBus1(data_a[1]),
    .DataBus2(data_a[2]), .DataBus3(data_a[3]),
    .DataBus4(data_a[4]), .DataBus5(data_a[5]),
    .DataBus6(data_a[6]), .DataBus7(data_a[7]),
    .busy(busy_a), .done(done_a), .count(cnt_a),
    .qcount0(qc_a[0]), .qcount1(qc_a[1]),
    .qcount2(qc_a[2]), .qcount3(qc_a[3])
  );

  even_count_scanner #(.EXCLUDE_ZERO(0)) dut_z0 (
    .clk(clk), .reset(reset), .start(start),
    .AddressBus0(addr_z[0]), .AddressBus1(addr_z[1]),
    .AddressBus2(addr_z[2]), .AddressBus3(addr_z[3]),
    .AddressBus4(addr_z[4]), .AddressBus5(addr_z[5]),
    .AddressBus6(addr_z[6]), .AddressBus7(addr_z[7]),
    .DataBus0(data_z[0]), .DataBus1(data_z[1]),
    .DataBus2(data_z[2]), .DataBus3(data_z[3]),
    .DataBus4(data_z[4]), .DataBus5(data_z[5]),
    .DataBus6(data_z[6]), .DataBus7(data_z[7]),
    .busy(busy_z), .done(done_z), .count(cnt_z),
    .qcount0(qc_z[0]), .qcount1(qc_z[1]),
    .qcount2(qc_z[2]), .qcount3(qc_z[3])
  );

  function automatic res_t model(input bit ez);
    res_t r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i][0] == 1'b0 && (!ez || mem[i] != 8'd0)) begin
        r.c = r.c + 9'd1;
        r.q[i / 64] = r.q[i / 64] + 7'd1;
      end
    end
    return r;
  endfunction

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Runs one sweep; pulse_at >= 0 re-asserts start at that SCAN cycle.
  task automatic run_sweep(input string name, input int pulse_at);
    res_t ea, ez;
    int   bc;
    int   fin;
    logic [8:0] sum;
    sb_q.push_back(model(1'b1));
    sb_q.push_back(model(1'b0));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || cnt_a !== 9'd0 || cnt_z !== 9'd0) begin
      failures++;
      $display("FAIL %s start_clear busy=%b cnt=%0d/%0d need busy=1 cnt=0",
               name, busy_a, cnt_a, cnt_z);
    end
    bc  = 0;
    fin = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_a) begin
        fin = c;
        break;
      end
      if (busy_a) bc++;
      if (c == 31) begin
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (addr_a[k] !== 8'(248 + k)) begin
            failures++;
            $display("FAIL %s addr%0d last_beat got=%0d need=%0d",
                     name, k, addr_a[k], 248 + k);
          end
        end
      end
      if (c == pulse_at) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    checks++;
    if (fin != 32 || bc != 32) begin
      failures++;
      $display("FAIL %s timing done_at=%0d busy_cycles=%0d need 32/32",
               name, fin, bc);
    end
    ea = sb_q.pop_front();
    ez = sb_q.pop_front();
    checks++;
    if (cnt_a !== ea.c) begin
      failures++;
      $display("FAIL %s count got=%0d need=%0d", name, cnt_a, ea.c);
    end
    checks++;
    if (cnt_z !== ez.c) begin
      failures++;
      $display("FAIL %s count_z0 got=%0d need=%0d", name, cnt_z, ez.c);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (qc_a[k] !== ea.q[k] || qc_z[k] !== ez.q[k]) begin
        failures++;
        $display("FAIL %s qcount%0d got=%0d/%0d need=%0d/%0d",
                 name, k, qc_a[k], qc_z[k], ea.q[k], ez.q[k]);
      end
    end
    sum = 9'(qc_a[0]) + 9'(qc_a[1]) + 9'(qc_a[2]) + 9'(qc_a[3]);
    checks++;
    if (sum !== cnt_a || done_z !== 1'b1) begin
      failures++;
      $display("FAIL %s invariant qsum=%0d count=%0d done_z0=%b",
               name, sum, cnt_a, done_z);
    end
  endtask

  task automatic test_reset;
    fill(8'd2);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 9'd0 ||
        qc_a[0] !== 7'd0 || qc_a[3] !== 7'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b cnt=%0d need 0/0/0",
               busy_a, done_a, cnt_a);
    end
    checks++;
    if (addr_a[0] !== 8'd0 || addr_a[7] !== 8'd7) begin
      failures++;
      $display("FAIL reset_addr a0=%0d a7=%0d need 0/7",
               addr_a[0], addr_a[7]);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b done=%b need 0/0",
               busy_a, done_a);
    end
  endtask

  task automatic test_all_two;
    fill(8'd2);
    run_sweep("all_two", -1);
  endtask

  task automatic test_all_one;
    fill(8'd1);
    run_sweep("all_one", -1);
  endtask

  task automatic test_all_zero;
    fill(8'd0);
    run_sweep("all_zero", -1);
  endtask

  task automatic test_sparse;
    fill(8'd1);
    mem[5]   = 8'd4;
    mem[70]  = 8'd6;
    mem[200] = 8'h80;
    mem[255] = 8'd3;
    run_sweep("sparse", -1);
    checks++;
    if (cnt_a !== 9'd3 || qc_a[0] !== 7'd1 || qc_a[1] !== 7'd1 ||
        qc_a[2] !== 7'd0 || qc_a[3] !== 7'd1) begin
      failures++;
      $display("FAIL sparse_fixed cnt=%0d q=%0d,%0d,%0d,%0d need 3 q=1,1,0,1",
               cnt_a, qc_a[0], qc_a[1], qc_a[2], qc_a[3]);
    end
  endtask

  task automatic test_start_ignored;
    fill(8'd1);
    mem[5]   = 8'd4;
    mem[70]  = 8'd6;
    mem[200] = 8'h80;
    mem[255] = 8'd3;
    run_sweep("start_ignored", 10);
  endtask

  task automatic test_reset_mid;
    fill(8'd2);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c <= 12; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 9'd0 ||
        qc_a[0] !== 7'd0 || qc_a[1] !== 7'd0 || cnt_z !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b cnt=%0d q0=%0d need zeros",
               busy_a, done_a, cnt_a, qc_a[0]);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a[0] !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_idle busy=%b done=%b a0=%0d need 0/0/0",
               busy_a, done_a, addr_a[0]);
    end
    run_sweep("after_reset", -1);
  endtask

  task automatic test_back_to_back;
    checks++;
    if (cnt_a !== 9'd256 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL b2b_pre cnt=%0d done=%b need 256/1", cnt_a, done_a);
    end
    fill(8'd1);
    run_sweep("back_to_back", -1);
  endtask

  initial begin
    fill(8'd0);
    test_reset();
    test_all_two();
    test_all_one();
    test_all_zero();
    test_sparse();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
